// File: rtl/pico_resp_encoder_if.sv
// Pico memory port plus L1.5 return channel seen by the response encoder.
// slave = encoder side; master = the pico core / L1.5 side that drives requests and returns.
interface pico_resp_encoder_if;
    logic        pico_mem_valid;
    logic [31:0] pico_mem_addr;
    logic [3:0]  pico_mem_wstrb;
    logic        l15_picodecoder_ack;
    logic        l15_picoencoder_val;
    logic [3:0]  l15_picoencoder_returntype;
    logic [63:0] l15_picoencoder_data_0;
    logic [63:0] l15_picoencoder_data_1;
    logic        picoencoder_l15_req_ack;
    logic        pico_mem_ready;
    logic [31:0] pico_mem_rdata;
    logic        pico_int;
    logic        resp_timeout;
    logic        spurious_resp;

    modport slave (
        input  pico_mem_valid, pico_mem_addr, pico_mem_wstrb, l15_picodecoder_ack,
        input  l15_picoencoder_val, l15_picoencoder_returntype,
        input  l15_picoencoder_data_0, l15_picoencoder_data_1,
        output picoencoder_l15_req_ack, pico_mem_ready, pico_mem_rdata,
        output pico_int, resp_timeout, spurious_resp
    );

    modport master (
        output pico_mem_valid, pico_mem_addr, pico_mem_wstrb, l15_picodecoder_ack,
        output l15_picoencoder_val, l15_picoencoder_returntype,
        output l15_picoencoder_data_0, l15_picoencoder_data_1,
        input  picoencoder_l15_req_ack, pico_mem_ready, pico_mem_rdata,
        input  pico_int, resp_timeout, spurious_resp
    );
endinterface

// File: rtl/pico_resp_encoder.sv
// Matches L1.5 returns to the single outstanding pico request and drives ready/rdata one cycle after the return.
// Never backpressures L1.5: every return is acked combinationally in the cycle it is valid.
module pico_resp_encoder #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pico_resp_encoder_if.slave   bus
);
    localparam logic [3:0] LOAD_RET   = 4'b0000;
    localparam logic [3:0] ST_ACK     = 4'b0100;
    localparam logic [3:0] INT_RET    = 4'b0111;
    localparam logic [3:0] ATOMIC_RES = 4'b1110;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        RESP      = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [1:0]           sel_q;
    logic                 req_is_store;
    logic [TIMEOUT_W-1:0] wdog_cnt;
    logic [31:0]          rdata_q;
    logic                 int_q;
    logic                 timeout_q;
    logic                 spurious_q;

    logic        req_accept;
    logic        is_cmpl;
    logic [1:0]  sel_eff;
    logic [31:0] word;
    logic [31:0] word_le;
    logic        unused_bits;

    assign req_accept = bus.l15_picodecoder_ack & bus.pico_mem_valid;
    assign is_cmpl    = bus.l15_picoencoder_val &
                        ((bus.l15_picoencoder_returntype == LOAD_RET) ||
                         (bus.l15_picoencoder_returntype == ST_ACK)   ||
                         (bus.l15_picoencoder_returntype == ATOMIC_RES));

    // In IDLE only a same-cycle bypass can complete, so the live address picks the word.
    assign sel_eff = (state == IDLE) ? bus.pico_mem_addr[3:2] : sel_q;

    always_comb begin
        word = 32'h0;
        case (sel_eff)
            2'b00: word = bus.l15_picoencoder_data_0[63:32];
            2'b01: word = bus.l15_picoencoder_data_0[31:0];
            2'b10: word = bus.l15_picoencoder_data_1[63:32];
            2'b11: word = bus.l15_picoencoder_data_1[31:0];
            default: word = 32'h0;
        endcase
    end

    assign word_le = {word[7:0], word[15:8], word[23:16], word[31:24]};

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_accept)
                    state_next = is_cmpl ? RESP : WAIT_RESP;
            end
            WAIT_RESP: begin
                if (is_cmpl)
                    state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            sel_q        <= 2'b00;
            req_is_store <= 1'b0;
            wdog_cnt     <= '0;
            rdata_q      <= 32'h0;
            int_q        <= 1'b0;
            timeout_q    <= 1'b0;
            spurious_q   <= 1'b0;
        end else begin
            state <= state_next;
            int_q <= bus.l15_picoencoder_val &&
                     (bus.l15_picoencoder_returntype == INT_RET);

            if (state == IDLE && req_accept) begin
                sel_q        <= bus.pico_mem_addr[3:2];
                req_is_store <= (bus.pico_mem_wstrb != 4'b0000);
            end

            if (state_next == RESP)
                rdata_q <= (bus.l15_picoencoder_returntype == ST_ACK) ? 32'h0 : word_le;
            else
                rdata_q <= 32'h0;

            if (state == IDLE && is_cmpl && !req_accept)
                spurious_q <= 1'b1;

            // Counter saturates at all-ones; the flag is raised on the edge it gets there.
            if (state != WAIT_RESP && state_next == WAIT_RESP) begin
                wdog_cnt <= '0;
            end else if (state == WAIT_RESP && state_next == WAIT_RESP) begin
                if (wdog_cnt != {TIMEOUT_W{1'b1}})
                    wdog_cnt <= wdog_cnt + 1'b1;
                if (wdog_cnt >= {{(TIMEOUT_W-1){1'b1}}, 1'b0})
                    timeout_q <= 1'b1;
            end
        end
    end

    // Request kind is captured for visibility only; completion deliberately ignores it.
    assign unused_bits = ^{bus.pico_mem_addr[31:4], bus.pico_mem_addr[1:0], req_is_store};

    assign bus.picoencoder_l15_req_ack = bus.l15_picoencoder_val;
    assign bus.pico_mem_ready          = (state == RESP);
    assign bus.pico_mem_rdata          = rdata_q;
    assign bus.pico_int                = int_q;
    assign bus.resp_timeout            = timeout_q;
    assign bus.spurious_resp           = spurious_q;
endmodule

// File: tb/tb_pico_resp_encoder.sv
// Directed bench for pico_resp_encoder with a 4-bit watchdog; each step is checked against hand-computed values.
module tb_pico_resp_encoder;
    localparam logic [3:0] LOAD_RET   = 4'b0000;
    localparam logic [3:0] ST_ACK     = 4'b0100;
    localparam logic [3:0] INT_RET    = 4'b0111;
    localparam logic [3:0] EVICT_REQ  = 4'b0011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    pico_resp_encoder_if bus ();

    pico_resp_encoder #(.TIMEOUT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.pico_mem_valid             = 1'b0;
        bus.pico_mem_addr              = 32'h0;
        bus.pico_mem_wstrb             = 4'h0;
        bus.l15_picodecoder_ack        = 1'b0;
        bus.l15_picoencoder_val        = 1'b0;
        bus.l15_picoencoder_returntype = 4'h0;
        bus.l15_picoencoder_data_0     = 64'h0;
        bus.l15_picoencoder_data_1     = 64'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},    {31'h0, bus.pico_mem_ready}, 32'h0);
        check({tag, "_rdata"},    bus.pico_mem_rdata, 32'h0);
        check({tag, "_int"},      {31'h0, bus.pico_int}, 32'h0);
        check({tag, "_timeout"},  {31'h0, bus.resp_timeout}, 32'h0);
        check({tag, "_spurious"}, {31'h0, bus.spurious_resp}, 32'h0);
        check({tag, "_reqack"},   {31'h0, bus.picoencoder_l15_req_ack}, 32'h0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        check_all_zero("reset");
        rst_n = 1'b1;

        // Load from 0x8: word 2 of the line, byte-swapped.
        bus.pico_mem_valid = 1'b1; bus.pico_mem_addr = 32'h0000_0008; bus.pico_mem_wstrb = 4'h0;
        bus.l15_picodecoder_ack = 1'b1;
        cyc();
        bus.l15_picodecoder_ack = 1'b0;
        check("load_wait_ready", {31'h0, bus.pico_mem_ready}, 32'h0);
        bus.l15_picoencoder_val = 1'b1; bus.l15_picoencoder_returntype = LOAD_RET;
        bus.l15_picoencoder_data_0 = 64'hDEAD_BEEF_CAFE_F00D;
        bus.l15_picoencoder_data_1 = 64'h1122_3344_5566_7788;
        #1;
        check("load_reqack", {31'h0, bus.picoencoder_l15_req_ack}, 32'h1);
        check("load_no_early_ready", {31'h0, bus.pico_mem_ready}, 32'h0);
        cyc();
        idle_inputs();
        check("load_ready", {31'h0, bus.pico_mem_ready}, 32'h1);
        check("load_rdata", bus.pico_mem_rdata, 32'h4433_2211);
        cyc();
        check("load_ready_drop", {31'h0, bus.pico_mem_ready}, 32'h0);
        check("load_rdata_clear", bus.pico_mem_rdata, 32'h0);

        // Store completed by ST_ACK carrying nonzero data: rdata must still be 0.
        bus.pico_mem_valid = 1'b1; bus.pico_mem_addr = 32'h0000_0010; bus.pico_mem_wstrb = 4'hF;
        bus.l15_picodecoder_ack = 1'b1;
        cyc();
        bus.l15_picodecoder_ack = 1'b0;
        bus.l15_picoencoder_val = 1'b1; bus.l15_picoencoder_returntype = ST_ACK;
        bus.l15_picoencoder_data_0 = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("store_reqack", {31'h0, bus.picoencoder_l15_req_ack}, 32'h1);
        cyc();
        idle_inputs();
        check("store_ready", {31'h0, bus.pico_mem_ready}, 32'h1);
        check("store_rdata", bus.pico_mem_rdata, 32'h0);
        cyc();
        check("store_ready_drop", {31'h0, bus.pico_mem_ready}, 32'h0);

        // Bypass: decoder ack and LOAD_RET in the same IDLE cycle, addr 0x4 selects data_0[31:0].
        bus.pico_mem_valid = 1'b1; bus.pico_mem_addr = 32'h0000_0004; bus.pico_mem_wstrb = 4'h0;
        bus.l15_picodecoder_ack = 1'b1;
        bus.l15_picoencoder_val = 1'b1; bus.l15_picoencoder_returntype = LOAD_RET;
        bus.l15_picoencoder_data_0 = 64'hAABB_CCDD_0102_0304;
        cyc();
        idle_inputs();
        check("bypass_ready", {31'h0, bus.pico_mem_ready}, 32'h1);
        check("bypass_rdata", bus.pico_mem_rdata, 32'h0403_0201);
        check("bypass_not_spurious", {31'h0, bus.spurious_resp}, 32'h0);
        cyc();
        check("bypass_ready_drop", {31'h0, bus.pico_mem_ready}, 32'h0);

        // INT_RET and an eviction while waiting: pulse only, then a normal completion.
        bus.pico_mem_valid = 1'b1; bus.pico_mem_addr = 32'h0000_0000; bus.pico_mem_wstrb = 4'h0;
        bus.l15_picodecoder_ack = 1'b1;
        cyc();
        bus.l15_picodecoder_ack = 1'b0;
        bus.l15_picoencoder_val = 1'b1; bus.l15_picoencoder_returntype = INT_RET;
        cyc();
        check("int_pulse", {31'h0, bus.pico_int}, 32'h1);
        check("int_no_ready", {31'h0, bus.pico_mem_ready}, 32'h0);
        bus.l15_picoencoder_returntype = EVICT_REQ;
        #1;
        check("evict_reqack", {31'h0, bus.picoencoder_l15_req_ack}, 32'h1);
        cyc();
        check("int_pulse_end", {31'h0, bus.pico_int}, 32'h0);
        check("evict_no_ready", {31'h0, bus.pico_mem_ready}, 32'h0);
        bus.l15_picoencoder_returntype = LOAD_RET;
        bus.l15_picoencoder_data_0 = 64'h1234_5678_9ABC_DEF0;
        cyc();
        idle_inputs();
        check("after_int_ready", {31'h0, bus.pico_mem_ready}, 32'h1);
        check("after_int_rdata", bus.pico_mem_rdata, 32'h7856_3412);
        check("after_int_nospur", {31'h0, bus.spurious_resp}, 32'h0);
        cyc();

        // Unsolicited ST_ACK in IDLE: acked, dropped, sticky spurious flag.
        bus.l15_picoencoder_val = 1'b1; bus.l15_picoencoder_returntype = ST_ACK;
        #1;
        check("spur_reqack", {31'h0, bus.picoencoder_l15_req_ack}, 32'h1);
        cyc();
        idle_inputs();
        check("spur_no_ready", {31'h0, bus.pico_mem_ready}, 32'h0);
        check("spur_flag", {31'h0, bus.spurious_resp}, 32'h1);
        cyc();
        check("spur_sticky", {31'h0, bus.spurious_resp}, 32'h1);

        // Watchdog: 14 waiting cycles are not enough, the 15th raises the flag.
        bus.pico_mem_valid = 1'b1; bus.pico_mem_addr = 32'h0000_000C;
        bus.l15_picodecoder_ack = 1'b1;
        cyc();
        bus.l15_picodecoder_ack = 1'b0;
        for (int i = 0; i < 14; i++) cyc();
        check("wdog_before", {31'h0, bus.resp_timeout}, 32'h0);
        cyc();
        check("wdog_fire", {31'h0, bus.resp_timeout}, 32'h1);
        for (int i = 0; i < 3; i++) cyc();
        check("wdog_sticky", {31'h0, bus.resp_timeout}, 32'h1);
        check("wdog_no_ready", {31'h0, bus.pico_mem_ready}, 32'h0);

        // Reset abandons the request and clears sticky flags.
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check_all_zero("rst2");

        // A late return for the abandoned request now counts as unsolicited.
        bus.l15_picoencoder_val = 1'b1; bus.l15_picoencoder_returntype = LOAD_RET;
        cyc();
        idle_inputs();
        check("post_rst_no_ready", {31'h0, bus.pico_mem_ready}, 32'h0);
        check("post_rst_spur", {31'h0, bus.spurious_resp}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
